// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a big-endian program image from a byte source into instruction memory, then releases the CPU
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   start                   begin a load (sampled only while idle)
//   rx_valid, rx_data       byte source handshake and payload
//   rx_ready                loader can accept a byte this cycle
//   imem_we/addr/wdata      one-cycle instruction-memory write port
//   cpu_hold                holds the processor until the image is written
//   done                    load complete, sticky until reset
//   overflow                image held more words than the memory depth
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, LAST, DONE} state_t;
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);
    state_t      state, state_nx;
    logic [15:0] len;
    logic [1:0]  byte_cnt;
    logic [16:0] word_cnt;
    logic [31:0] asm_word;
    logic        xfer, word_done, last_word;
    assign xfer      = rx_valid & rx_ready;
    assign word_done = (state == DATA) && xfer && (byte_cnt == 2'd3);
    assign last_word = (word_cnt + 17'd1) == {1'b0, len};
    assign done      = state == DONE;
    assign cpu_hold  = state != DONE;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        rx_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
        case (state)
            IDLE:    state_nx = start ? LEN_HI : IDLE;
            LEN_HI:  state_nx = xfer ? LEN_LO : LEN_HI;
            LEN_LO:  state_nx = !xfer ? LEN_LO : ({len[15:8], rx_data} == 16'd0) ? DONE : DATA;
            DATA:    state_nx = (word_done && last_word) ? LAST : DATA;
            LAST:    state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    // The write port has its own registers so a byte accepted during the
    // write cycle can already start assembling the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            len        <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            asm_word   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            overflow   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (state == LEN_HI && xfer) len[15:8] <= rx_data;
            if (state == LEN_LO && xfer) begin
                len[7:0] <= rx_data;
                byte_cnt <= '0;
                word_cnt <= '0;
            end
            if (state == DATA && xfer) begin
                asm_word <= {asm_word[23:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (word_done) begin
                imem_wdata <= {asm_word[23:0], rx_data};
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_we    <= word_cnt < DEPTH;
                overflow   <= overflow | (word_cnt >= DEPTH);
                word_cnt   <= word_cnt + 17'd1;
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table-driven and randomized checks of imem_boot_loader against an image-level reference model
module tb_imem_boot_loader;
    localparam int D8 = 256;
    localparam int D2 = 4;
    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        ready8, we8, hold8, done8, ovf8;
    logic [7:0]  addr8;
    logic [31:0] wd8;
    logic        ready2, we2, hold2, done2, ovf2;
    logic [1:0]  addr2;
    logic [31:0] wd2;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          last_xfer;
    int          we_cyc8, done_cyc8, done_cyc2;
    logic [39:0] got8[$];
    logic [39:0] got2[$];

    imem_boot_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(ready8), .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8),
        .cpu_hold(hold8), .done(done8), .overflow(ovf8)
    );
    imem_boot_loader #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(ready2), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
        .cpu_hold(hold2), .done(done2), .overflow(ovf2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            got8.delete();
            got2.delete();
            we_cyc8   = -1;
            done_cyc8 = -1;
            done_cyc2 = -1;
        end else begin
            if (we8) begin
                got8.push_back({addr8, wd8});
                we_cyc8 = cyc;
            end
            if (we2) got2.push_back({6'b0, addr2, wd2});
            if (done8 && done_cyc8 < 0) done_cyc8 = cyc;
            if (done2 && done_cyc2 < 0) done_cyc2 = cyc;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int mode);
        int g;
        g = (mode == 0) ? 0 : 1 + $urandom_range(0, 2);
        rx_valid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ready8) begin
                @(posedge clk);
                #1;
                last_xfer = cyc;
                rx_valid  = 1'b0;
                return;
            end
        end
        rx_valid = 1'b0;
        check("xfer_timeout", 64'd0, 64'd1);
    endtask

    // Reference: word i of the image lands at address i if it fits in memory.
    task automatic run_load(input string nm, input bit rst_first, input int n, input logic [31:0] w[$],
                            input int mode, input int ew8, input int ew2, input int eovf2);
        logic [39:0] e8[$];
        logic [39:0] e2[$];
        logic [15:0] n16;
        n16 = 16'(n);
        if (rst_first) do_reset();
        do_start();
        send_byte(n16[15:8], mode);
        send_byte(n16[7:0], mode);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 4; j++) send_byte(w[i][31-8*j -: 8], mode);
        for (int k = 0; k < 20 && !done8; k++) @(negedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (i < D8) e8.push_back({8'(i), w[i]});
            if (i < D2) e2.push_back({6'b0, 2'(i), w[i]});
        end
        check({nm, " nwr8"}, 64'(got8.size()), 64'(ew8 >= 0 ? ew8 : e8.size()));
        check({nm, " nwr2"}, 64'(got2.size()), 64'(ew2 >= 0 ? ew2 : e2.size()));
        for (int i = 0; i < e8.size(); i++)
            check($sformatf("%s wr8[%0d]", nm, i), i < got8.size() ? 64'(got8[i]) : '1, 64'(e8[i]));
        for (int i = 0; i < e2.size(); i++)
            check($sformatf("%s wr2[%0d]", nm, i), i < got2.size() ? 64'(got2[i]) : '1, 64'(e2[i]));
        check({nm, " done/hold8"}, {62'b0, done8, hold8}, 64'b10);
        check({nm, " done/hold2"}, {62'b0, done2, hold2}, 64'b10);
        check({nm, " ovf8"}, 64'(ovf8), 64'(n > D8));
        check({nm, " ovf2"}, 64'(ovf2), 64'(eovf2 >= 0 ? eovf2 : (n > D2)));
        check({nm, " done_lat8"}, 64'(done_cyc8 - last_xfer), 64'(n == 0 ? 0 : 1));
        check({nm, " done_lat2"}, 64'(done_cyc2 - last_xfer), 64'(n == 0 ? 0 : 1));
        if (n > 0) check({nm, " we_lat8"}, 64'(we_cyc8), 64'(last_xfer));
    endtask

    typedef struct {
        string       nm;
        int          n;
        logic [31:0] w0, w1, w2, w3, w4;
        int          mode;
        int          ew8, ew2, eovf2;
    } vec_t;

    initial begin
        vec_t        tbl[6];
        logic [31:0] q[$];
        int          n;
        tbl[0] = '{"two_words", 2, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 2, 2, 0};
        tbl[1] = '{"empty",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{"two_gaps",  2, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 1, 2, 2, 0};
        tbl[3] = '{"overflow",  5, 1, 2, 3, 4, 5, 0, 5, 4, 1};
        tbl[4] = '{"one_gaps",  1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 1, 0};
        tbl[5] = '{"full_fit",  4, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3, 0, 1, 4, 4, 0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("reset8 c%0d", i), {59'b0, hold8, ready8, we8, done8, ovf8}, 64'b10000);
            check($sformatf("reset2 c%0d", i), {59'b0, hold2, ready2, we2, done2, ovf2}, 64'b10000);
        end

        for (int t = 0; t < 6; t++) begin
            q = {tbl[t].w0, tbl[t].w1, tbl[t].w2, tbl[t].w3, tbl[t].w4};
            run_load(tbl[t].nm, 1'b1, tbl[t].n, q, tbl[t].mode, tbl[t].ew8, tbl[t].ew2, tbl[t].eovf2);
        end

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 6);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back($urandom);
            run_load($sformatf("rand%0d", r), 1'b1, n, q, $urandom_range(0, 1), -1, -1, -1);
        end

        do_reset();
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(negedge clk);
        check("abort no_write", 64'(got8.size()), 64'd0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort idle", {61'b0, hold8, ready8, done8}, 64'b100);
        q = {32'h12345678, 32'h9ABCDEF0};
        run_load("after_abort", 1'b0, 2, q, 0, 2, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
